// File: rtl/riscoffee_mem_arbiter_if.sv
// Fetch, load/store and RAM-side signals of the shared instruction/data RAM arbiter.
interface riscoffee_mem_arbiter_if;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        I_FLUSH;
  logic        I_GNT;
  logic        I_RVALID;
  logic [31:0] I_RDATA;
  logic        D_REQ;
  logic        D_WE;
  logic [2:0]  D_FUNCT3;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_GNT;
  logic        D_RVALID;
  logic [31:0] D_RDATA;
  logic        D_ERR;
  logic        M_DSEL;
  logic        M_WE;
  logic [2:0]  M_OP;
  logic [31:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic [31:0] M_RDATA;

  modport slave (
    input  I_REQ, I_ADDR, I_FLUSH, D_REQ, D_WE, D_FUNCT3, D_ADDR, D_WDATA, M_RDATA,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA, D_ERR,
           M_DSEL, M_WE, M_OP, M_ADDR, M_WDATA
  );

  modport master (
    output I_REQ, I_ADDR, I_FLUSH, D_REQ, D_WE, D_FUNCT3, D_ADDR, D_WDATA, M_RDATA,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA, D_ERR,
           M_DSEL, M_WE, M_OP, M_ADDR, M_WDATA
  );
endinterface

// File: rtl/riscoffee_mem_arbiter.sv
// Single-port RAM arbiter between fetch and load/store, with data priority,
// a fetch-starvation guard and load byte/half extraction on the response path.
module riscoffee_mem_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  riscoffee_mem_arbiter_if.slave  bus
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [2:0] OP_W = 3'b010;

  logic [SW-1:0]         r_starve;
  logic                  r_i_pend;
  logic                  r_d_pend;
  logic                  r_d_store;
  logic                  r_d_err;
  logic [2:0]            r_d_f3;
  logic [1:0]            r_d_off;

  logic                  w_illegal;
  logic                  w_misal;
  logic                  w_oor;
  logic                  w_err;
  logic                  w_force;
  logic                  w_ignt;
  logic                  w_dgnt;
  logic                  w_dram;
  logic                  w_store;
  logic                  w_irvalid;
  logic [DATA_WIDTH-1:0] w_ld_data;

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] word,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'd0, b};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = word;
    endcase
  endfunction

  always_comb begin
    w_illegal = (bus.D_FUNCT3 == 3'b011) || (bus.D_FUNCT3 == 3'b110) ||
                (bus.D_FUNCT3 == 3'b111);
    w_misal   = ((bus.D_FUNCT3[1:0] == 2'b01) && bus.D_ADDR[0]) ||
                ((bus.D_FUNCT3 == 3'b010) && (bus.D_ADDR[1:0] != 2'b00));
    w_oor     = |(bus.D_ADDR >> (ADDR_WIDTH + 2));
    w_err     = w_illegal || w_misal || w_oor;
    w_force   = bus.I_REQ && (r_starve == SW'(MAX_STARVE));
    // An erroring data request never touches the RAM, so fetch may share its cycle.
    w_dgnt    = RST_N && bus.D_REQ && (w_err || !w_force);
    w_ignt    = RST_N && bus.I_REQ && (w_force || !bus.D_REQ || w_err);
    w_dram    = w_dgnt && !w_err;
    w_store   = w_dram && bus.D_WE;
    w_irvalid = r_i_pend && !bus.I_FLUSH;
    w_ld_data = load_ext(bus.M_RDATA, r_d_f3, r_d_off);
  end

  assign bus.I_GNT    = w_ignt;
  assign bus.D_GNT    = w_dgnt;
  assign bus.M_DSEL   = w_dram;
  assign bus.M_WE     = w_store;
  assign bus.M_OP     = w_store ? bus.D_FUNCT3 : OP_W;
  assign bus.M_ADDR   = w_dram ? bus.D_ADDR :
                        (w_ignt ? (bus.I_ADDR & ~32'h3) : 32'd0);
  assign bus.M_WDATA  = w_store ? bus.D_WDATA : 32'd0;

  assign bus.I_RVALID = w_irvalid;
  assign bus.I_RDATA  = w_irvalid ? bus.M_RDATA : 32'd0;
  assign bus.D_RVALID = r_d_pend;
  assign bus.D_ERR    = r_d_pend && r_d_err;
  assign bus.D_RDATA  = (r_d_pend && !r_d_store && !r_d_err) ? w_ld_data : 32'd0;

  // Grant cycle -> response cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_starve  <= '0;
      r_i_pend  <= 1'b0;
      r_d_pend  <= 1'b0;
      r_d_store <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_f3    <= 3'b000;
      r_d_off   <= 2'b00;
    end else begin
      r_i_pend  <= w_ignt && !bus.I_FLUSH;
      r_d_pend  <= w_dgnt;
      r_d_store <= w_store;
      r_d_err   <= w_dgnt && w_err;
      r_d_f3    <= bus.D_FUNCT3;
      r_d_off   <= bus.D_ADDR[1:0];
      if (bus.I_REQ && !w_ignt) begin
        if (r_starve != SW'(MAX_STARVE)) r_starve <= r_starve + 1'b1;
      end else begin
        r_starve <= '0;
      end
    end
  end
endmodule

// File: tb/tb_riscoffee_mem_arbiter.sv
// Directed bench for riscoffee_mem_arbiter with a small byte-writable RAM model.
module tb_riscoffee_mem_arbiter;
  logic CLK;
  logic RST_N;
  int   total;
  int   bad;

  riscoffee_mem_arbiter_if bus ();

  riscoffee_mem_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .MAX_STARVE(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] ram [0:255];
  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
      ram[0] <= 32'h11;
      ram[1] <= 32'h22;
      ram[2] <= 32'h33;
    end else if (bus.M_WE) begin
      case (bus.M_OP[1:0])
        2'b00:   ram[bus.M_ADDR[9:2]][{bus.M_ADDR[1:0], 3'b000} +: 8] <= bus.M_WDATA[7:0];
        2'b01:   ram[bus.M_ADDR[9:2]][{bus.M_ADDR[1], 4'b0000} +: 16] <= bus.M_WDATA[15:0];
        default: ram[bus.M_ADDR[9:2]] <= bus.M_WDATA;
      endcase
    end
    bus.M_RDATA <= ram[bus.M_ADDR[9:2]];
  end

  task automatic idle();
    bus.I_REQ = 0; bus.I_ADDR = 0; bus.I_FLUSH = 0;
    bus.D_REQ = 0; bus.D_WE = 0; bus.D_FUNCT3 = 3'b010; bus.D_ADDR = 0; bus.D_WDATA = 0;
  endtask

  task automatic dreq(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
    bus.D_REQ = 1; bus.D_WE = we; bus.D_FUNCT3 = f3; bus.D_ADDR = a; bus.D_WDATA = wd;
  endtask

  task automatic test_reset();
    @(negedge CLK); bus.I_REQ = 1; bus.D_REQ = 1; #1;
    if ({bus.I_GNT, bus.D_GNT, bus.M_WE, bus.D_RVALID, bus.I_RVALID} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000",
                      {bus.I_GNT, bus.D_GNT, bus.M_WE, bus.D_RVALID, bus.I_RVALID});
    end
    total++;
    if (bus.M_ADDR !== 32'd0) begin
      bad++; $display("FAIL reset_maddr got=%h exp=0", bus.M_ADDR);
    end
    total++;
    @(negedge CLK); idle(); RST_N = 1;
  endtask

  task automatic test_fetch();
    logic [31:0] addrs [4] = '{32'h0, 32'h4, 32'h8, 32'h0};
    logic [31:0] exp_d [4] = '{32'h0, 32'h11, 32'h22, 32'h33};
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); idle();
      bus.I_REQ = (k < 3); bus.I_ADDR = addrs[k]; #1;
      if (bus.I_GNT !== (k < 3)) begin
        bad++; $display("FAIL fetch_gnt[%0d] got=%b exp=%b", k, bus.I_GNT, (k < 3));
      end
      total++;
      if (k < 3 && (bus.M_ADDR !== addrs[k] || bus.M_OP !== 3'b010 || bus.M_DSEL !== 1'b0)) begin
        bad++; $display("FAIL fetch_mdrive[%0d] got=%h/%b/%b exp=%h/010/0", k,
                        bus.M_ADDR, bus.M_OP, bus.M_DSEL, addrs[k]);
      end
      total++;
      if (k > 0 && (bus.I_RVALID !== 1'b1 || bus.I_RDATA !== exp_d[k])) begin
        bad++; $display("FAIL fetch_rdata[%0d] got=%b/%h exp=1/%h", k, bus.I_RVALID,
                        bus.I_RDATA, exp_d[k]);
      end
      total++;
    end
  endtask

  task automatic test_starvation();
    logic exp_i;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); idle();
      bus.I_REQ = 1; bus.I_ADDR = 32'h20;
      dreq(1'b0, 3'b010, 32'h10, 32'h0); #1;
      exp_i = (k == 4) || (k == 9);
      if (bus.I_GNT !== exp_i || bus.D_GNT !== !exp_i) begin
        bad++; $display("FAIL starve_pattern[%0d] got=I%b/D%b exp=I%b/D%b", k,
                        bus.I_GNT, bus.D_GNT, exp_i, !exp_i);
      end
      total++;
    end
    @(negedge CLK); idle();
  endtask

  task automatic test_store_load();
    @(negedge CLK); idle(); dreq(1'b1, 3'b000, 32'h102, 32'hAB); #1;
    if (bus.D_GNT !== 1'b1 || bus.M_WE !== 1'b1 || bus.M_OP !== 3'b000 ||
        bus.M_DSEL !== 1'b1 || bus.M_ADDR !== 32'h102 || bus.M_WDATA !== 32'hAB) begin
      bad++; $display("FAIL sb_drive got=g%b we%b op%b sel%b a%h wd%h exp=g1 we1 op000 sel1 a102 wdab",
                      bus.D_GNT, bus.M_WE, bus.M_OP, bus.M_DSEL, bus.M_ADDR, bus.M_WDATA);
    end
    total++;
    @(negedge CLK); dreq(1'b0, 3'b000, 32'h102, 32'h0); #1;
    if (bus.M_WE !== 1'b0 || bus.M_OP !== 3'b010 || bus.D_RVALID !== 1'b1 ||
        bus.D_RDATA !== 32'h0 || bus.D_ERR !== 1'b0) begin
      bad++; $display("FAIL sb_ack got=we%b op%b v%b d%h e%b exp=we0 op010 v1 d0 e0",
                      bus.M_WE, bus.M_OP, bus.D_RVALID, bus.D_RDATA, bus.D_ERR);
    end
    total++;
    @(negedge CLK); dreq(1'b0, 3'b100, 32'h102, 32'h0); #1;
    if (bus.D_RVALID !== 1'b1 || bus.D_RDATA !== 32'hFFFFFFAB) begin
      bad++; $display("FAIL lb got=%b/%h exp=1/ffffffab", bus.D_RVALID, bus.D_RDATA);
    end
    total++;
    @(negedge CLK); dreq(1'b1, 3'b001, 32'h102, 32'hABCD); #1;
    if (bus.D_RDATA !== 32'h000000AB) begin
      bad++; $display("FAIL lbu got=%h exp=000000ab", bus.D_RDATA);
    end
    total++;
    @(negedge CLK); dreq(1'b0, 3'b001, 32'h102, 32'h0); #1;
    if (bus.D_RVALID !== 1'b1 || bus.D_RDATA !== 32'h0) begin
      bad++; $display("FAIL sh_ack got=%b/%h exp=1/0", bus.D_RVALID, bus.D_RDATA);
    end
    total++;
    @(negedge CLK); idle(); #1;
    if (bus.D_RDATA !== 32'hFFFFABCD || bus.D_ERR !== 1'b0) begin
      bad++; $display("FAIL lh got=%h/%b exp=ffffabcd/0", bus.D_RDATA, bus.D_ERR);
    end
    total++;
  endtask

  task automatic test_error();
    logic [31:0] ea [4] = '{32'h101, 32'h0040_0000, 32'h100, 32'h102};
    logic [2:0]  ef [4] = '{3'b010, 3'b010, 3'b011, 3'b010};
    logic        ew [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); idle();
      bus.I_REQ = 1; bus.I_ADDR = 32'h4;
      dreq(ew[k], ef[k], ea[k], 32'hDEAD_BEEF); #1;
      if (bus.D_GNT !== 1'b1 || bus.I_GNT !== 1'b1 || bus.M_WE !== 1'b0 ||
          bus.M_DSEL !== 1'b0 || bus.M_ADDR !== 32'h4) begin
        bad++; $display("FAIL err_grant[%0d] got=d%b i%b we%b sel%b a%h exp=d1 i1 we0 sel0 a4",
                        k, bus.D_GNT, bus.I_GNT, bus.M_WE, bus.M_DSEL, bus.M_ADDR);
      end
      total++;
      @(negedge CLK); idle(); #1;
      if (bus.D_RVALID !== 1'b1 || bus.D_ERR !== 1'b1 || bus.D_RDATA !== 32'h0 ||
          bus.I_RVALID !== 1'b1 || bus.I_RDATA !== 32'h22) begin
        bad++; $display("FAIL err_resp[%0d] got=v%b e%b d%h iv%b id%h exp=v1 e1 d0 iv1 id22",
                        k, bus.D_RVALID, bus.D_ERR, bus.D_RDATA, bus.I_RVALID, bus.I_RDATA);
      end
      total++;
    end
  endtask

  task automatic test_flush();
    @(negedge CLK); idle(); bus.I_REQ = 1; bus.I_ADDR = 32'h8; #1;
    if (bus.I_GNT !== 1'b1) begin
      bad++; $display("FAIL flush_gnt got=%b exp=1", bus.I_GNT);
    end
    total++;
    @(negedge CLK); bus.I_ADDR = 32'h0; bus.I_FLUSH = 1; #1;
    if (bus.I_RVALID !== 1'b0 || bus.I_GNT !== 1'b1) begin
      bad++; $display("FAIL flush_next got=v%b g%b exp=v0 g1", bus.I_RVALID, bus.I_GNT);
    end
    total++;
    @(negedge CLK); bus.I_ADDR = 32'h4; bus.I_FLUSH = 0; #1;
    if (bus.I_RVALID !== 1'b0) begin
      bad++; $display("FAIL flush_at_grant got=%b exp=0", bus.I_RVALID);
    end
    total++;
    @(negedge CLK); idle(); #1;
    if (bus.I_RVALID !== 1'b1 || bus.I_RDATA !== 32'h22) begin
      bad++; $display("FAIL flush_after got=%b/%h exp=1/22", bus.I_RVALID, bus.I_RDATA);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); idle(); dreq(1'b0, 3'b010, 32'h8, 32'h0); #1;
    if (bus.D_GNT !== 1'b1 || bus.M_DSEL !== 1'b1) begin
      bad++; $display("FAIL rstmid_gnt got=%b/%b exp=1/1", bus.D_GNT, bus.M_DSEL);
    end
    total++;
    #2 RST_N = 0; #1;
    if (bus.D_GNT !== 1'b0 || bus.M_DSEL !== 1'b0 || bus.M_ADDR !== 32'h0) begin
      bad++; $display("FAIL rstmid_async got=g%b sel%b a%h exp=g0 sel0 a0",
                      bus.D_GNT, bus.M_DSEL, bus.M_ADDR);
    end
    total++;
    @(negedge CLK); idle(); #1;
    if (bus.D_RVALID !== 1'b0) begin
      bad++; $display("FAIL rstmid_hold got=%b exp=0", bus.D_RVALID);
    end
    total++;
    @(negedge CLK); RST_N = 1;
    @(negedge CLK); #1;
    if (bus.D_RVALID !== 1'b0 || bus.D_ERR !== 1'b0) begin
      bad++; $display("FAIL rstmid_release got=%b/%b exp=0/0", bus.D_RVALID, bus.D_ERR);
    end
    total++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST_N = 0;
    idle();
    repeat (3) @(negedge CLK);
    test_reset();
    test_fetch();
    test_starvation();
    test_store_load();
    test_error();
    test_flush();
    test_reset_mid();
    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/riscoffee_mem_arbiter.md
Name: riscoffee_mem_arbiter

Overview:
- Shares the single-port, 1-cycle-read-latency instruction/data RAM between the fetch stage (I-port) and the load/store stage (D-port).
- Arbitrates per cycle, with data priority and a fetch-starvation guard.
- Drives the RAM address, write and op controls, and routes each read response back to its requester.
- Performs load byte/half extraction and sign/zero extension itself, so RAM output formatting never depends on the op of a later cycle.

Parameters:
- ADDR_WIDTH, 20, RAM word-address width; the byte space is 2^(ADDR_WIDTH+2).
- DATA_WIDTH, 32, word width.
- MAX_STARVE, 4, consecutive cycles a pending fetch may lose before it is forced to win.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous reset, active-low.
- I_REQ  in  1  fetch request; I_ADDR held stable until I_GNT.
- I_ADDR  in  32  fetch byte address; word-aligned, bits [1:0] ignored.
- I_FLUSH  in  1  cancels the fetch response due next cycle.
- I_GNT  out  1  fetch accepted this cycle.
- I_RVALID  out  1  fetch data valid.
- I_RDATA  out  32  fetched word.
- D_REQ  in  1  data request; all D_* inputs held stable until D_GNT.
- D_WE  in  1  1 = store, 0 = load.
- D_FUNCT3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- D_ADDR  in  32  data byte address.
- D_WDATA  in  32  store data, right-aligned.
- D_GNT  out  1  data request accepted.
- D_RVALID  out  1  response: load data or store acknowledge.
- D_RDATA  out  32  extended load data; 0 for stores and errors.
- D_ERR  out  1  valid with D_RVALID; misaligned or out-of-range access.
- M_DSEL  out  1  1 = RAM uses the data address, 0 = the fetch address.
- M_WE  out  1  RAM write enable.
- M_OP  out  3  funct3 presented to the RAM.
- M_ADDR  out  32  RAM byte address.
- M_WDATA  out  32  RAM write data.
- M_RDATA  in  32  RAM read word, valid the cycle after issue.

Behaviour:
- **Reset (RST_N low, asynchronous):** all outputs 0, starvation counter 0, pending-response register cleared. A response outstanding at reset is discarded and never emitted.
- **Error check (combinational on D inputs):**
  - Misaligned: H/HU with D_ADDR[0]=1; W with D_ADDR[1:0]≠0.
  - Out-of-range: D_ADDR[31:ADDR_WIDTH+2]≠0.
  - Illegal funct3 (011, 110, 111) is also an error.
- **Arbitration each cycle, in order:**
  1. D_REQ with error: D_GNT=1 and the RAM is not used by D, so a fetch may be granted in the same cycle.
  2. Fetch forced (starvation counter = MAX_STARVE and I_REQ): I_GNT=1, D_GNT=0.
  3. Legal D_REQ: D_GNT=1.
  4. Otherwise I_REQ: I_GNT=1.
- **Starvation counter:**
  - Increments when I_REQ=1 and I_GNT=0.
  - Clears on I_GNT or when I_REQ=0.
  - Saturates at MAX_STARVE.
- **RAM drive, same cycle as the grant (combinational):**
  - Fetch: M_DSEL=0, M_ADDR=I_ADDR, M_OP=010, M_WE=0.
  - Data load: M_DSEL=1, M_ADDR=D_ADDR, M_OP=010 (full-word read always), M_WE=0.
  - Data store: M_DSEL=1, M_ADDR=D_ADDR, M_OP=D_FUNCT3, M_WE=1, M_WDATA=D_WDATA.
  - Idle or error-only: M_DSEL=0, M_WE=0, M_ADDR=0, M_OP=010.
- **Pending register:** on grant, registers {owner, store, err, funct3, addr[1:0]}. One response per port at most per cycle.
- **Response, cycle N+1 after a grant in cycle N (registered valid, data combinational from M_RDATA):**
  - Fetch: I_RVALID=1, I_RDATA=M_RDATA. Suppressed entirely if I_FLUSH=1 in cycle N+1 or in cycle N while granting.
  - Load: D_RVALID=1. D_RDATA = selected byte/half from M_RDATA at offset addr[1:0], sign-extended (B/H) or zero-extended (BU/HU); W passes through.
  - Store: D_RVALID=1, D_RDATA=0.
  - Error: D_RVALID=1, D_ERR=1, D_RDATA=0, with no RAM write.
- **Throughput and ordering:** back-to-back grants are allowed; full throughput is 1 access per cycle. Responses return in issue order. Requesters accept responses unconditionally; there is no response backpressure.
- **I_FLUSH** does not cancel a request being granted in the same cycle except as stated above; the grant still consumes the port.

Test Plan:
- Fetch only, I_ADDR=0x0,0x4,0x8 back-to-back, RAM words 0x11,0x22,0x33 -> I_GNT every cycle; I_RDATA=0x11,0x22,0x33 one cycle later each.
- Both request continuously with MAX_STARVE=4 -> D_GNT 4 cycles, then I_GNT 1 cycle; pattern repeats and the counter clears after each I_GNT.
- Store SB 0xAB to 0x102, then LB from 0x102 -> M_WE=1, M_OP=000; load responds D_RDATA=0xFFFFFFAB. LBU from 0x102 -> 0x000000AB. LH from 0x102 over word 0xABCD_0000 -> 0xFFFFABCD.
- LW at 0x101 with a simultaneous I_REQ -> D_GNT=1 and I_GNT=1 in the same cycle; next cycle D_RVALID=1, D_ERR=1, D_RDATA=0, I_RVALID=1; M_WE stays 0. Repeat with D_ADDR=0x0040_0000 (out of range for ADDR_WIDTH=20) and with D_FUNCT3=011 -> same error response.
- Fetch granted, I_FLUSH=1 the next cycle -> I_RVALID stays 0; the fetch after it returns normally.
- Load granted, RST_N low mid-cycle before the response -> all outputs 0 immediately; no D_RVALID after reset release.
